// File: rtl/mmul_uop_sequencer_pkg.sv
// Shared types and defaults for the MMUL micro-op sequencer and its register remap.
package mmul_uop_sequencer_pkg;

    typedef enum logic [1:0] {
        UOP_PASS = 2'd0,
        UOP_ACC  = 2'd1,
        UOP_RED  = 2'd2
    } uop_mode_t;

    localparam int unsigned MMUL_UOP_COUNT = 3;
    localparam int unsigned IDX_W          = 3;

endpackage

// File: rtl/mmul_reg_remap.sv
// Combinational register-index rewrite for one MMUL micro-op; non-MMUL passes through.
module mmul_reg_remap
    import mmul_uop_sequencer_pkg::*;
#(
    parameter int unsigned NR_BITS = 6
) (
    input  logic               mmul_i,
    input  logic [IDX_W-1:0]   idx_i,
    input  logic               last_i,
    input  logic [NR_BITS-1:0] rd_i,
    input  logic [NR_BITS-1:0] rs1_i,
    input  logic [NR_BITS-1:0] rs2_i,
    output logic [NR_BITS-1:0] rd_o,
    output logic [NR_BITS-1:0] rs1_o,
    output logic [NR_BITS-1:0] rs2_o,
    output uop_mode_t          mode_o
);

    logic [NR_BITS-1:0] k_c;

    assign k_c = NR_BITS'(idx_i);

    // Accumulate steps walk rd/rs1 forward; the final reduce step folds back onto rd.
    always_comb begin
        rd_o   = rd_i;
        rs1_o  = rs1_i;
        rs2_o  = rs2_i;
        mode_o = UOP_PASS;
        if (mmul_i) begin
            if (last_i) begin
                mode_o = UOP_RED;
                rs1_o  = rd_i;
                rs2_o  = rd_i + NR_BITS'(1);
            end else begin
                mode_o = UOP_ACC;
                rd_o   = rd_i + k_c;
                rs1_o  = rs1_i + k_c;
                rs2_o  = rs1_i + k_c + NR_BITS'(2);
            end
        end
    end

endmodule

// File: rtl/mmul_uop_sequencer.sv
// Expands a decoded MMUL into UOP_COUNT ALU micro-ops; other instructions pass through.
// Optional perf counters enabled by defining MMUL_SEQ_PERF_EN.
module mmul_uop_sequencer
    import mmul_uop_sequencer_pkg::*;
#(
    parameter int unsigned NR_BITS   = 6,
    parameter int unsigned UOP_COUNT = MMUL_UOP_COUNT,
    parameter int unsigned PAYLOAD_W = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_is_mmul,
    input  logic [NR_BITS-1:0]   in_rd,
    input  logic [NR_BITS-1:0]   in_rs1,
    input  logic [NR_BITS-1:0]   in_rs2,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NR_BITS-1:0]   out_rd,
    output logic [NR_BITS-1:0]   out_rs1,
    output logic [NR_BITS-1:0]   out_rs2,
    output logic [1:0]           out_mode,
    output logic [2:0]           out_idx,
    output logic                 out_last,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 busy
`ifdef MMUL_SEQ_PERF_EN
    ,
    output logic [31:0]          perf_mmul_count,
    output logic [31:0]          perf_uop_count
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEQ  = 1'b1
    } seq_state_e;

    seq_state_e       state_q;
    logic [IDX_W-1:0] idx_q;
    logic             mmul_last_c;
    logic             last_c;
    logic             fire_c;
    uop_mode_t        mode_c;

    assign mmul_last_c = (idx_q == IDX_W'(UOP_COUNT - 1));
    assign last_c      = in_is_mmul ? mmul_last_c : 1'b1;
    assign fire_c      = in_valid && out_ready;

    mmul_reg_remap #(
        .NR_BITS(NR_BITS)
    ) u_remap (
        .mmul_i (in_is_mmul),
        .idx_i  (idx_q),
        .last_i (mmul_last_c),
        .rd_i   (in_rd),
        .rs1_i  (in_rs1),
        .rs2_i  (in_rs2),
        .rd_o   (out_rd),
        .rs1_o  (out_rs1),
        .rs2_o  (out_rs2),
        .mode_o (mode_c)
    );

    assign out_valid   = in_valid;
    assign out_mode    = 2'(mode_c);
    assign out_idx     = in_is_mmul ? idx_q : IDX_W'(0);
    assign out_last    = last_c;
    assign out_payload = in_payload;
    assign in_ready    = out_ready && last_c;
    assign busy        = (state_q == S_SEQ);

    // Sequence state advances only on an accepted micro-op, so backpressure just stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else if (fire_c) begin
            if (last_c) begin
                state_q <= S_IDLE;
                idx_q   <= '0;
            end else begin
                state_q <= S_SEQ;
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

`ifdef MMUL_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_mmul_count <= '0;
            perf_uop_count  <= '0;
        end else if (fire_c && in_is_mmul) begin
            perf_uop_count <= perf_uop_count + 32'd1;
            if (mmul_last_c) begin
                perf_mmul_count <= perf_mmul_count + 32'd1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    // Upstream must hold the MMUL valid until its final micro-op is taken.
    a_no_drop_in_seq: assert property (@(posedge clk) disable iff (reset)
        (state_q == S_SEQ) |-> in_valid)
        else $error("mmul_uop_sequencer: in_valid dropped mid-sequence");
`endif

endmodule

// File: tb/tb_mmul_uop_sequencer.sv
// Randomized self-checking bench for mmul_uop_sequencer against a list-of-micro-ops model.
module tb_mmul_uop_sequencer;

    localparam int unsigned NRB = 6;
    localparam int unsigned UC  = 3;
    localparam int unsigned PW  = 128;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic           in_is_mmul;
    logic [NRB-1:0] in_rd;
    logic [NRB-1:0] in_rs1;
    logic [NRB-1:0] in_rs2;
    logic [PW-1:0]  in_payload;
    logic           out_valid;
    logic           out_ready;
    logic [NRB-1:0] out_rd;
    logic [NRB-1:0] out_rs1;
    logic [NRB-1:0] out_rs2;
    logic [1:0]     out_mode;
    logic [2:0]     out_idx;
    logic           out_last;
    logic [PW-1:0]  out_payload;
    logic           busy;
`ifdef MMUL_SEQ_PERF_EN
    logic [31:0]    perf_mmul_count;
    logic [31:0]    perf_uop_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mmul_uop_sequencer #(
        .NR_BITS  (NRB),
        .UOP_COUNT(UC),
        .PAYLOAD_W(PW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_is_mmul (in_is_mmul),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_mode   (out_mode),
        .out_idx    (out_idx),
        .out_last   (out_last),
        .out_payload(out_payload),
        .busy       (busy)
`ifdef MMUL_SEQ_PERF_EN
        ,
        .perf_mmul_count(perf_mmul_count),
        .perf_uop_count (perf_uop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Micro-op number k of an instruction, straight from the expansion rules.
    function automatic void ref_uop(input bit mmul, input logic [NRB-1:0] rd, input logic [NRB-1:0] rs1,
                                    input logic [NRB-1:0] rs2, input int k,
                                    output logic [NRB-1:0] e_rd, output logic [NRB-1:0] e_rs1,
                                    output logic [NRB-1:0] e_rs2, output logic [1:0] e_mode,
                                    output logic e_last);
        int s_rd, s_rs1;
        if (!mmul) begin
            e_rd = rd; e_rs1 = rs1; e_rs2 = rs2; e_mode = 2'd0; e_last = 1'b1;
        end else if (k < int'(UC) - 1) begin
            s_rd  = int'(rd) + k;
            s_rs1 = int'(rs1) + k;
            e_rd   = NRB'(s_rd % 64);
            e_rs1  = NRB'(s_rs1 % 64);
            e_rs2  = NRB'((s_rs1 + 2) % 64);
            e_mode = 2'd1;
            e_last = 1'b0;
        end else begin
            e_rd   = rd;
            e_rs1  = rd;
            e_rs2  = NRB'((int'(rd) + 1) % 64);
            e_mode = 2'd2;
            e_last = 1'b1;
        end
    endfunction

    // Present one instruction until all its micro-ops are accepted. rmode: 0 ready=1, 1 random, 2 1,0,0,1,1.
    task automatic issue(input bit mmul, input logic [NRB-1:0] rd, input logic [NRB-1:0] rs1,
                         input logic [NRB-1:0] rs2, input int rmode);
        logic [PW-1:0]  pl;
        logic [NRB-1:0] e_rd, e_rs1, e_rs2;
        logic [1:0]     e_mode;
        logic           e_last;
        int n, k, cyc;
        pl  = {$urandom(), $urandom(), $urandom(), $urandom()};
        n   = mmul ? int'(UC) : 1;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 200) begin
            @(negedge clk);
            in_valid   = 1'b1;
            in_is_mmul = mmul;
            in_rd      = rd;
            in_rs1     = rs1;
            in_rs2     = rs2;
            in_payload = pl;
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = !(cyc == 1 || cyc == 2);
            endcase
            ref_uop(mmul, rd, rs1, rs2, k, e_rd, e_rs1, e_rs2, e_mode, e_last);
            #1;
            check("out_valid", PW'(out_valid), PW'(1'b1));
            check("out_rd",    PW'(out_rd),    PW'(e_rd));
            check("out_rs1",   PW'(out_rs1),   PW'(e_rs1));
            check("out_rs2",   PW'(out_rs2),   PW'(e_rs2));
            check("out_mode",  PW'(out_mode),  PW'(e_mode));
            check("out_idx",   PW'(out_idx),   PW'(k));
            check("out_last",  PW'(out_last),  PW'(e_last));
            check("payload",   out_payload,    pl);
            check("in_ready",  PW'(in_ready),  PW'(out_ready && e_last));
            check("busy",      PW'(busy),      PW'(k != 0));
            if (out_ready) k++;
            cyc++;
        end
        if (k < n) check("timeout", PW'(k), PW'(n));
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid   = 1'b0;
        in_is_mmul = 1'($urandom_range(0, 1));
        out_ready  = 1'($urandom_range(0, 1));
        #1;
        check("idle_valid", PW'(out_valid), PW'(1'b0));
        check("idle_busy",  PW'(busy),      PW'(1'b0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_is_mmul = 1'b0;
        in_rd      = '0;
        in_rs1     = '0;
        in_rs2     = '0;
        in_payload = '0;
        out_ready  = 1'b0;
        do_reset();

        // Reset state
        #1;
        check("rst_busy",  PW'(busy),      PW'(1'b0));
        check("rst_valid", PW'(out_valid), PW'(1'b0));
        in_valid   = 1'b1;
        in_is_mmul = 1'b1;
        #1;
        check("rst_idx",   PW'(out_idx),   PW'(0));
        in_valid   = 1'b0;

`ifdef MMUL_SEQ_PERF_EN
        do_reset();
        #1;
        check("perf_rst_mmul", PW'(perf_mmul_count), PW'(0));
        check("perf_rst_uop",  PW'(perf_uop_count),  PW'(0));
        issue(1'b1, 6'd1, 6'd2, 6'd3, 0);
        issue(1'b1, 6'd4, 6'd5, 6'd6, 1);
        issue(1'b0, 6'd7, 6'd8, 6'd9, 0);
        idle_cycle();
        check("perf_mmul", PW'(perf_mmul_count), PW'(2));
        check("perf_uop",  PW'(perf_uop_count),  PW'(6));
`endif

        // Directed cases
        issue(1'b0, 6'd5,  6'd6,  6'd7,  0);
        issue(1'b1, 6'd10, 6'd20, 6'd0,  0);
        issue(1'b1, 6'd10, 6'd20, 6'd0,  2);
        issue(1'b1, 6'd63, 6'd62, 6'd17, 0);
        issue(1'b1, 6'd1,  6'd2,  6'd3,  0);
        issue(1'b0, 6'd9,  6'd9,  6'd9,  0);

        // Reset mid-sequence, then the same MMUL is re-presented from uop0
        @(negedge clk);
        in_valid = 1'b1; in_is_mmul = 1'b1; in_rd = 6'd30; in_rs1 = 6'd40; in_rs2 = 6'd0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("pre_rst_idx",  PW'(out_idx), PW'(1));
        check("pre_rst_busy", PW'(busy),    PW'(1'b1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_idx",  PW'(out_idx), PW'(0));
        check("post_rst_busy", PW'(busy),    PW'(1'b0));
        issue(1'b1, 6'd30, 6'd40, 6'd0, 1);

        // Randomized stream with backpressure and idle gaps
        for (int i = 0; i < 80; i++) begin
            issue(1'($urandom_range(0, 1)), NRB'($urandom()), NRB'($urandom()), NRB'($urandom()),
                  int'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
